// File: rtl/queue_drain_pkg.sv
// ============================================================================
// queue_drain_pkg : shared types and widths for the queue drain scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package queue_drain_pkg;

  localparam int WORD_W = 8;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/drain_timeout_cnt.sv
// ============================================================================
// drain_timeout_cnt : saturating idle counter; expired_o once TIMEOUT_CYC-1 reached
// Rev 1.0
// ============================================================================
`default_nettype none

module drain_timeout_cnt #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] base;

  // A clear drops the history, but the current enabled cycle still counts.
  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (en_i && (base != CNT_MAX)) begin
      cnt_d = base + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/queue_drain_ctrl.sv
// ============================================================================
// queue_drain_ctrl : pops the byte queue and forwards words over valid/ready.
// Optional word counter enabled by QUEUE_DRAIN_CTRL_STATS_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module queue_drain_ctrl
  import queue_drain_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DRAIN_WM    = 2,
  parameter int HIGH_WM     = 7,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LEN_W-1:0]  q_len_i,
  input  logic [WORD_W-1:0] q_data_i,
  output logic              q_dequeue_o,
  output logic              des_enable_o,
  input  logic              flush_i,
  output logic              m_valid_o,
  output logic [WORD_W-1:0] m_data_o,
  input  logic              m_ready_i,
  output logic              busy_o
`ifdef QUEUE_DRAIN_CTRL_STATS_EN
  ,
  output logic [15:0]       word_count_o
`endif
);

  localparam logic [LEN_W-1:0] DRAIN_WM_L = LEN_W'(DRAIN_WM);
  localparam logic [LEN_W-1:0] HIGH_WM_L  = LEN_W'(HIGH_WM);

  generate
    if (!((DRAIN_WM > 0) && (DRAIN_WM <= HIGH_WM) && (HIGH_WM <= DEPTH) &&
          (DEPTH <= 15) && (TIMEOUT_CYC >= 2))) begin : g_bad_params
      $error("queue_drain_ctrl: illegal parameter combination");
    end
  endgenerate

  drain_state_t      state_q;
  drain_state_t      state_d;
  logic              drain_q;
  logic              drain_d;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] data_d;
  logic              des_en_q;
  logic [LEN_W-1:0]  len_prev_q;

  logic len_nz;
  logic at_wm;
  logic at_hwm;
  logic len_changed;
  logic to_expired;
  logic to_clr;
  logic to_en;
  logic start;

  assign len_nz      = (q_len_i != '0);
  assign at_wm       = (q_len_i >= DRAIN_WM_L);
  assign at_hwm      = (q_len_i >= HIGH_WM_L);
  assign len_changed = (q_len_i != len_prev_q);

  assign start = (state_q == IDLE) && len_nz &&
                 (at_wm || flush_i || (to_expired && !len_changed));

  assign to_en  = (state_q == IDLE) && len_nz && !at_wm && !flush_i && !start;
  assign to_clr = (state_q != IDLE) || start || !len_nz || len_changed;

  drain_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      drain_q    <= 1'b0;
      data_q     <= '0;
      des_en_q   <= 1'b1;
      len_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      data_q     <= data_d;
      des_en_q   <= !at_hwm;
      len_prev_q <= q_len_i;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = POP;
          drain_d = 1'b1;
        end
      end
      POP: begin
        // A stale zero length means the queue emptied underneath us.
        if (len_nz) begin
          state_d = CAPTURE;
        end else begin
          state_d = IDLE;
          drain_d = 1'b0;
        end
      end
      CAPTURE: begin
        data_d  = q_data_i;
        state_d = SEND;
      end
      SEND: begin
        if (m_ready_i) begin
          if (len_nz && drain_q) begin
            state_d = POP;
          end else begin
            state_d = IDLE;
            drain_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        drain_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    q_dequeue_o = (state_q == POP) && len_nz;
    m_valid_o   = (state_q == SEND);
    busy_o      = (state_q != IDLE);
  end

  assign m_data_o     = data_q;
  assign des_enable_o = des_en_q;

`ifdef QUEUE_DRAIN_CTRL_STATS_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_cnt_q <= '0;
    end else if (m_valid_o && m_ready_i) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign word_count_o = word_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_queue_drain_ctrl.sv
// ============================================================================
// tb_queue_drain_ctrl : scoreboard bench with a behavioural byte-queue model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_queue_drain_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] q_len_i = '0;
  logic [7:0] q_data_i = '0;
  logic       flush_i = 1'b0;
  logic       m_ready_i = 1'b0;
  logic       q_dequeue_o;
  logic       des_enable_o;
  logic       m_valid_o;
  logic [7:0] m_data_o;
  logic       busy_o;
`ifdef QUEUE_DRAIN_CTRL_STATS_EN
  logic [15:0] word_count_o;
`endif

  always #5 clock = ~clock;

  queue_drain_ctrl #(
    .DEPTH       (8),
    .DRAIN_WM    (2),
    .HIGH_WM     (7),
    .TIMEOUT_CYC (64)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .q_len_i      (q_len_i),
    .q_data_i     (q_data_i),
    .q_dequeue_o  (q_dequeue_o),
    .des_enable_o (des_enable_o),
    .flush_i      (flush_i),
    .m_valid_o    (m_valid_o),
    .m_data_o     (m_data_o),
    .m_ready_i    (m_ready_i),
    .busy_o       (busy_o)
`ifdef QUEUE_DRAIN_CTRL_STATS_EN
    ,
    .word_count_o (word_count_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  byte unsigned fifo[$];
  byte unsigned exp_q[$];

  logic       s_deq, s_valid, s_busy, s_des;
  logic [7:0] s_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample mid-cycle, score handshakes, then apply the queue's pop.
  task automatic tick();
    @(negedge clock);
    s_deq   = q_dequeue_o;
    s_valid = m_valid_o;
    s_data  = m_data_o;
    s_busy  = busy_o;
    s_des   = des_enable_o;
    if (s_deq) check("deq_nonempty", 32'(fifo.size() != 0), 32'd1);
    if (s_valid && m_ready_i) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check("sb_data", 32'(s_data), 32'(exp_q.pop_front()));
    end
    @(posedge clock);
    #1;
    if (s_deq && fifo.size() != 0) q_data_i = fifo.pop_front();
    q_len_i = 4'(fifo.size());
  endtask

  task automatic push(input byte unsigned b);
    fifo.push_back(b);
    exp_q.push_back(b);
    q_len_i = 4'(fifo.size());
  endtask

  task automatic drain_wait(input string tag, input int budget);
    bit done = 1'b0;
    m_ready_i = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = !s_busy && (fifo.size() == 0) && (exp_q.size() == 0);
    end
    check({tag, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = s_valid;
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop_at;

    repeat (2) @(posedge clock);
    #1;
    check("rst_deq",   32'(q_dequeue_o),  32'd0);
    check("rst_valid", 32'(m_valid_o),    32'd0);
    check("rst_data",  32'(m_data_o),     32'd0);
    check("rst_busy",  32'(busy_o),       32'd0);
    check("rst_desen", 32'(des_enable_o), 32'd1);
    reset = 1'b1;
    tick();

    // Watermark burst with ready held high
    m_ready_i = 1'b1;
    push(8'h99);
    push(8'h55);
    tick(); check("wm_c0_deq", 32'(s_deq), 32'd0); check("wm_c0_busy", 32'(s_busy), 32'd0);
    tick(); check("wm_pop1", 32'(s_deq), 32'd1); check("wm_pop1_busy", 32'(s_busy), 32'd1);
    tick(); check("wm_cap_valid", 32'(s_valid), 32'd0);
    tick(); check("wm_send_valid", 32'(s_valid), 32'd1); check("wm_data1", 32'(s_data), 32'h99);
    tick(); check("wm_pop2", 32'(s_deq), 32'd1);
    tick(); check("wm_cap2_valid", 32'(s_valid), 32'd0);
    tick(); check("wm_send2_valid", 32'(s_valid), 32'd1); check("wm_data2", 32'(s_data), 32'h55);
    tick(); check("wm_idle", 32'(s_busy), 32'd0);

    // Back-pressure in SEND
    m_ready_i = 1'b0;
    push(8'hF0);
    push(8'h11);
    wait_valid("bp", 10);
    check("bp_data0", 32'(s_data), 32'hF0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid_hold", 32'(s_valid), 32'd1);
      check("bp_data_hold", 32'(s_data), 32'hF0);
      check("bp_no_deq", 32'(s_deq), 32'd0);
    end
    drain_wait("bp", 40);

    // Idle timeout with a single word
    m_ready_i = 1'b1;
    push(8'hA5);
    pop_at = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (s_deq) begin
        pop_at = i;
        break;
      end
    end
    check("to_pop_cycle", 32'(pop_at), 32'd64);
    drain_wait("to", 20);

    // High watermark throttle
    m_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) push(8'(8'h20 + i));
    tick(); check("hwm_c0_desen", 32'(s_des), 32'd1);
    tick(); check("hwm_c1_desen", 32'(s_des), 32'd0); check("hwm_c1_deq", 32'(s_deq), 32'd1);
    tick(); check("hwm_c2_desen", 32'(s_des), 32'd0);
    tick(); check("hwm_c3_desen", 32'(s_des), 32'd1);
    drain_wait("hwm", 100);

    // Full queue
    m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
    tick(); check("full_c0_desen", 32'(s_des), 32'd1);
    tick(); check("full_c1_desen", 32'(s_des), 32'd0); check("full_c1_deq", 32'(s_deq), 32'd1);
    drain_wait("full", 100);

    // Flush below watermark, flush dropped mid-burst
    m_ready_i = 1'b1;
    flush_i = 1'b1;
    push(8'h3C);
    tick(); check("fl_c0_deq", 32'(s_deq), 32'd0);
    tick(); check("fl_c1_deq", 32'(s_deq), 32'd1);
    flush_i = 1'b0;
    push(8'h4D);
    tick();
    tick();
    tick(); check("fl_burst_hold", 32'(s_deq), 32'd1);
    drain_wait("fl", 20);

    // Flush together with watermark: single pulse
    flush_i = 1'b1;
    push(8'hE1);
    push(8'hE2);
    tick();
    tick(); check("flwm_pop", 32'(s_deq), 32'd1);
    tick(); check("flwm_no_dbl1", 32'(s_deq), 32'd0);
    tick(); check("flwm_no_dbl2", 32'(s_deq), 32'd0);
    flush_i = 1'b0;
    drain_wait("flwm", 20);

    // Asynchronous reset while a word waits in SEND
    m_ready_i = 1'b0;
    push(8'h77);
    push(8'h88);
    wait_valid("rs", 10);
    tick();
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid_o), 32'd0);
    check("arst_busy",  32'(busy_o),    32'd0);
    check("arst_data",  32'(m_data_o),  32'd0);
    void'(exp_q.pop_front());
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rs_no_spurious", 32'(s_deq), 32'd0);
    end
    flush_i = 1'b1;
    drain_wait("rs", 20);
    flush_i = 1'b0;

`ifdef QUEUE_DRAIN_CTRL_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("st_rst", 32'(word_count_o), 32'd0);
    for (int i = 0; i < 150; i++) begin
      push(8'(i));
      push(8'(i + 1));
      drain_wait("st", 40);
    end
    check("st_count300", 32'(word_count_o), 32'd300);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
